regfile_write_sched: RTL
========================

Name: regfile_write_sched

Overview:
- Shares the register file's single write port between two requesters.
  - The in-order pipeline writeback (WB) stage, which cannot be stalled in-cycle.
  - The long-latency multicycle unit (MC: mul/div/load-miss).
- Buffers MC results until a free write slot appears.
- Keeps a 32-entry pending-write scoreboard so issue logic stalls on RAW/WAW hazards against in-flight MC destinations.
- Sits between writeback/MC outputs and the register file write port (write_en/write_id/write_data).

Parameters:
- MC_BUF_DEPTH, 2: MC result buffer entries (power of two, >= 2).
- STARVE_LIMIT, 4: consecutive cycles a buffered MC result may be blocked by WB before a pipeline bubble is forced (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- wb_valid  in  1  WB stage holds a result this cycle
- wb_id  in  5  WB destination register
- wb_data  in  32  WB result
- mc_valid  in  1  MC offers a result
- mc_ready  out  1  scheduler can accept the MC result
- mc_id  in  5  MC destination register
- mc_data  in  32  MC result
- issue_valid  in  1  instruction issuing this cycle
- issue_mc  in  1  issuing instruction targets MC
- issue_rd  in  5  destination of issuing instruction
- issue_rs1  in  5  source 1 of issuing instruction
- issue_rs2  in  5  source 2 of issuing instruction
- issue_stall  out  1  comb: rs1, rs2 or rd is pending
- stall_pipe  out  1  registered: upstream must inject a WB bubble next cycle
- write_en  out  1  to register file
- write_id  out  5  to register file
- write_data  out  32  to register file

Behaviour:
- Reset (sync, rst=1 at posedge):
  - Buffer emptied, pending vector cleared, starve counter = 0, stall_pipe = 0.
  - While rst is high: mc_ready=0, write_en=0, write_id=0, write_data=0.
  - Reset mid-operation drops buffered results and pending bits; no write is issued in the reset cycle.
- Write port is combinational from the current-cycle inputs and the buffer head.
  - WB has absolute priority: wb_valid && wb_id!=0 → write_en=1, write_id=wb_id, write_data=wb_data.
  - A WB slot with wb_valid=0 or wb_id==0 is free.
  - Free slot and buffer non-empty → buffer head is written and popped that cycle.
  - Otherwise write_en=0, write_id=0, write_data=0.
- MC handshake:
  - A transfer occurs when mc_valid && mc_ready at posedge.
  - mc_ready = !rst && (buffer not full).
  - Push on transfer; a simultaneous push and pop on a full buffer is not allowed (mc_ready already low).
  - Push and pop in the same cycle on a non-full buffer keeps the count unchanged.
  - Entries are written in FIFO order; pointers wrap modulo MC_BUF_DEPTH.
  - Latency: transfer at cycle N → earliest regfile write at N+1.
  - mc_id==0 transfers are accepted and discarded, never written.
- Scoreboard (32-bit pending, bit 0 hardwired 0):
  - Set pending[issue_rd] when issue_valid && issue_mc && !issue_stall && issue_rd!=0.
  - Clear pending[id] when an MC entry with that id is written to the register file.
  - Same-cycle clear and set on the same id → set wins.
  - issue_stall = pending[issue_rs1] | pending[issue_rs2] | pending[issue_rd]. Covers RAW and WAW, so WB never overwrites a pending reg.
  - issue_stall is gated by issue_valid.
- Starvation control:
  - Counter increments each cycle the buffer is non-empty and WB holds the slot.
  - Counter resets to 0 on any pop or when the buffer is empty.
  - When counter == STARVE_LIMIT-1 and still blocked, stall_pipe=1 for exactly one cycle at the next posedge.
  - Upstream guarantees wb_valid=0 in the cycle stall_pipe is high, so the buffered entry drains then.
  - Counter then clears.

Optional Feature:
- REGFILE_SCHED_BYPASS_EN defined: if the buffer is empty, the WB slot is free and mc_valid=1, the MC result is written straight to the register file in the same cycle. No push occurs; the pending bit clears that cycle (0-cycle latency).
- Undefined: every MC result passes through the buffer (min 1-cycle latency).

Decomposition:
- common_pkg additions:
  - typedef reg_id_t (logic [4:0])
  - typedef mc_wr_t (packed struct: reg_id_t id; logic [31:0] data)
  - constant REG_COUNT=32
- One sub-module, regfile_wr_fifo: synchronous FIFO of mc_wr_t with push/pop/full/empty/head, parameterised by MC_BUF_DEPTH.
- Arbitration, scoreboard and starvation logic stay in the top.

Test Plan:
- Reset: drive mc_valid=1 with rst=1 for 2 cycles → mc_ready=0, write_en=0, no push. After rst deasserts, mc_ready=1 and the pending vector is 0.
- Free slot: issue x5 via MC, then MC delivers id=5/data=0xDEADBEEF with wb_valid=0 → write_en=1, id=5, data 0xDEADBEEF one cycle later (same cycle with the bypass macro). pending[5] clears and issue_stall on rs1=5 drops.
- Contention: WB writes x1..x6 on consecutive cycles while MC delivers id=7 → buffered. stall_pipe pulses once after 4 blocked cycles; x7 is written in the bubble cycle.
- Full buffer: MC pushes 2 results while WB is busy → mc_ready=0 on the third offer. The result is accepted only after a pop; write order stays FIFO.
- Hazards: issue MC with rd=9, then an instruction with rs2=9, then one with rd=9 → issue_stall=1 for both until x9 is written. An instruction with rd=0 never sets pending.
- Reset mid-flight: 1 buffered entry plus pending[12], assert rst one cycle → no write of x12, pending=0, buffer empty.

Source files
------------

// File: rtl/regfile_write_sched_pkg.sv
// Shared types for the register-file write scheduler: destination ids and buffered MC results.
package regfile_write_sched_pkg;

    localparam int REG_COUNT = 32;

    typedef logic [4:0] reg_id_t;

    typedef struct packed {
        reg_id_t     id;
        logic [31:0] data;
    } mc_wr_t;

endpackage

// File: rtl/regfile_wr_fifo.sv
// Synchronous FIFO holding MC results until the register-file write port has a free slot.
module regfile_wr_fifo
    import regfile_write_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  mc_wr_t din_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output mc_wr_t head_o
);

    localparam int AW = $clog2(DEPTH);

    mc_wr_t         mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap on plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/regfile_write_sched.sv
// Arbitrates the single register-file write port between WB (priority) and buffered MC results.
// Optional same-cycle MC bypass when the buffer is empty: define REGFILE_SCHED_BYPASS_EN.
module regfile_write_sched
    import regfile_write_sched_pkg::*;
#(
    parameter int MC_BUF_DEPTH = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_id,
    input  logic [31:0] wb_data,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_id,
    input  logic [31:0] mc_data,
    input  logic        issue_valid,
    input  logic        issue_mc,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    output logic        issue_stall,
    output logic        stall_pipe,
    output logic        write_en,
    output logic [4:0]  write_id,
    output logic [31:0] write_data
);

    localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

    logic                  wb_hold;
    logic                  buf_full, buf_empty;
    mc_wr_t                buf_head, buf_din;
    logic                  push, pop, bypass;
    logic [REG_COUNT-1:0]  pending_q, pending_d;
    logic [3:0]            starve_q, starve_d;
    logic                  stall_pipe_q, stall_pipe_d;

    assign wb_hold     = wb_valid && (wb_id != '0);
    assign mc_ready    = !rst && !buf_full;
    // id 0 results are accepted on the handshake but never stored.
    assign push        = mc_valid && mc_ready && (mc_id != '0) && !bypass;
    assign buf_din     = '{id: mc_id, data: mc_data};
    assign issue_stall = issue_valid &&
                         (pending_q[issue_rs1] | pending_q[issue_rs2] | pending_q[issue_rd]);
    assign stall_pipe  = stall_pipe_q;

    regfile_wr_fifo #(
        .DEPTH (MC_BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (buf_din),
        .pop_i   (pop),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .head_o  (buf_head)
    );

    always_comb begin
        write_en   = 1'b0;
        write_id   = '0;
        write_data = '0;
        pop        = 1'b0;
        bypass     = 1'b0;
        if (!rst) begin
            if (wb_hold) begin
                write_en   = 1'b1;
                write_id   = wb_id;
                write_data = wb_data;
            end else if (!buf_empty) begin
                write_en   = 1'b1;
                write_id   = buf_head.id;
                write_data = buf_head.data;
                pop        = 1'b1;
            end
`ifdef REGFILE_SCHED_BYPASS_EN
            else if (mc_valid && (mc_id != '0)) begin
                write_en   = 1'b1;
                write_id   = mc_id;
                write_data = mc_data;
                bypass     = 1'b1;
            end
`endif
        end
    end

    // A new MC issue on the same id overrides a retiring write, so set is applied last.
    always_comb begin
        pending_d = pending_q;
        if (pop) begin
            pending_d[buf_head.id] = 1'b0;
        end
        if (bypass) begin
            pending_d[mc_id] = 1'b0;
        end
        if (issue_valid && issue_mc && !issue_stall && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        starve_d     = starve_q;
        stall_pipe_d = 1'b0;
        if (buf_empty || pop) begin
            starve_d = '0;
        end else if (wb_hold) begin
            if (starve_q == STARVE_LAST) begin
                stall_pipe_d = 1'b1;
                starve_d     = '0;
            end else begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= '0;
            starve_q     <= '0;
            stall_pipe_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            starve_q     <= starve_d;
            stall_pipe_q <= stall_pipe_d;
        end
    end

endmodule
